// File: rtl/tune_pkg.sv
// Shared types and constants for the tune sequencer: FSM states, note-word layout, marker values.
package tune_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } state_t;

    // Note word is {period, duration}: duration in the low bits, period directly above it.
    localparam int DUR_LSB = 0;

    localparam int REST_PERIOD  = 0;
    localparam int END_DURATION = 0;

    function automatic int period_lsb(input int dur_w);
        return DUR_LSB + dur_w;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles tone every `period` clocks while enabled; period 0 is a rest.
module tone_gen
    import tune_pkg::*;
#(
    parameter int PERIOD_W = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tone
);

    logic [PERIOD_W-1:0] cnt;
    logic                tone_q;

    always_ff @(posedge clk) begin
        if (rst || !en || period == PERIOD_W'(REST_PERIOD)) begin
            cnt    <= '0;
            tone_q <= 1'b0;
        end else if (cnt == period - PERIOD_W'(1)) begin
            cnt    <= '0;
            tone_q <= ~tone_q;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

    // Gate with en so the pin drops the same cycle the sequencer leaves PLAY.
    assign tone = tone_q & en;

endmodule

// File: rtl/tune_sequencer.sv
// Steps through a registered note ROM and plays each {period, duration} word on the tone pin.
// Build option TUNE_GAP_EN inserts a one-tick silent GAP after every note.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// FETCH | note_addr presented to the ROM
// LOAD  | ROM word valid; latch period, end marker check
// PLAY  | tone running for duration ticks
// GAP   | one tick of silence between notes (TUNE_GAP_EN only)
module tune_sequencer
    import tune_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int ADDR_W   = 8,
    parameter int PERIOD_W = 18,
    parameter int DUR_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    output logic [ADDR_W-1:0]         note_addr,
    input  logic [PERIOD_W+DUR_W-1:0] note_data,
    output logic                      tone,
    output logic                      busy,
    output logic                      done
);

    localparam int                 TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = '1;
    localparam int                 PERIOD_LSB = period_lsb(DUR_W);

    state_t              state, state_nxt;
    logic [PERIOD_W-1:0] period_q;
    logic [TICK_W-1:0]   tick_cnt;
    logic [DUR_W-1:0]    dur_cnt;
    logic                done_nxt;
    logic                addr_inc;
    logic                note_end;

    logic [DUR_W-1:0]    ld_dur;
    logic [PERIOD_W-1:0] ld_period;
    logic                tick_tc;
    logic                dur_tc;

    assign ld_dur    = note_data[DUR_LSB +: DUR_W];
    assign ld_period = note_data[PERIOD_LSB +: PERIOD_W];
    assign tick_tc   = (tick_cnt == '0);
    assign dur_tc    = (dur_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        addr_inc  = 1'b0;
        note_end  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: state_nxt = LOAD;
            LOAD: begin
                if (ld_dur == DUR_W'(END_DURATION)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (tick_tc && dur_tc) begin
`ifdef TUNE_GAP_EN
                    state_nxt = GAP;
`else
                    note_end = 1'b1;
`endif
                end
            end
`ifdef TUNE_GAP_EN
            GAP:   if (tick_tc) note_end = 1'b1;
`endif
            default: state_nxt = IDLE;
        endcase

        // Last address finishes the tune instead of wrapping to word 0.
        if (note_end) begin
            if (note_addr == ADDR_LAST) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = FETCH;
                addr_inc  = 1'b1;
            end
        end

        if (stop) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
            addr_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            note_addr <= '0;
            period_q  <= '0;
            tick_cnt  <= '0;
            dur_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            done <= done_nxt;

            if (stop || (state == IDLE && start)) begin
                note_addr <= '0;
            end else if (addr_inc) begin
                note_addr <= note_addr + ADDR_W'(1);
            end

            // Timers reload on entry to PLAY/GAP and only count down while nonzero.
            if (state == LOAD) begin
                period_q <= ld_period;
                tick_cnt <= TICK_LAST;
                if (ld_dur != DUR_W'(END_DURATION)) begin
                    dur_cnt <= ld_dur - DUR_W'(1);
                end
            end else if (state == PLAY) begin
                if (tick_tc) begin
                    tick_cnt <= TICK_LAST;
                    if (!dur_tc) begin
                        dur_cnt <= dur_cnt - DUR_W'(1);
                    end
                end else begin
                    tick_cnt <= tick_cnt - TICK_W'(1);
                end
            end else if (state == GAP && !tick_tc) begin
                tick_cnt <= tick_cnt - TICK_W'(1);
            end
        end
    end

    assign busy = (state != IDLE);

    tone_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tone_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (state == PLAY),
        .period (period_q),
        .tone   (tone)
    );

endmodule

// File: tb/tb_tune_sequencer.sv
// Vector-table bench for tune_sequencer with a registered note ROM model (TICK_DIV=4, ADDR_W=3).
module tb_tune_sequencer;

    localparam int TICK_DIV = 4;
    localparam int ADDR_W   = 3;
    localparam int PERIOD_W = 18;
    localparam int DUR_W    = 8;
    localparam int NW       = PERIOD_W + DUR_W;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              start = 1'b0;
    logic              stop  = 1'b0;
    logic [ADDR_W-1:0] note_addr;
    logic [NW-1:0]     note_data = '0;
    logic              tone, busy, done;

    logic [NW-1:0]     rom [8];

    typedef struct {
        logic              start;
        logic              stop;
        logic              tone;
        logic              busy;
        logic              done;
        logic [ADDR_W-1:0] addr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    tune_sequencer #(
        .TICK_DIV (TICK_DIV),
        .ADDR_W   (ADDR_W),
        .PERIOD_W (PERIOD_W),
        .DUR_W    (DUR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .note_addr (note_addr),
        .note_data (note_data),
        .tone      (tone),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) note_data <= rom[note_addr];

    function automatic logic [NW-1:0] mk(input int p, input int d);
        return {PERIOD_W'(p), DUR_W'(d)};
    endfunction

    task automatic push(input logic st, input logic sp, input logic t, input logic b,
                        input logic d, input int a);
        vec_t v;
        v.start = st; v.stop = sp; v.tone = t; v.busy = b; v.done = d;
        v.addr  = ADDR_W'(a);
        vecs.push_back(v);
    endtask

    // One note as seen on the pins: FETCH, LOAD, duration*TICK_DIV clocks of tone, optional gap.
    task automatic add_note(input int p, input int d, input int a);
        push(0, 0, 0, 1, 0, a);
        push(0, 0, 0, 1, 0, a);
        for (int k = 0; k < d * TICK_DIV; k++)
            push(0, 0, (p == 0) ? 1'b0 : 1'((k / p) % 2), 1, 0, a);
`ifdef TUNE_GAP_EN
        for (int k = 0; k < TICK_DIV; k++) push(0, 0, 0, 1, 0, a);
`endif
    endtask

    task automatic add_end_marker(input int a);
        push(0, 0, 0, 1, 0, a);
        push(0, 0, 0, 1, 0, a);
        push(0, 0, 0, 0, 1, a);
        push(0, 0, 0, 0, 0, a);
    endtask

    task automatic compare(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: tone/busy/done/addr got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run(input string tag);
        vec_t v, e;
        foreach (vecs[i]) begin
            v     = vecs[i];
            start = v.start;
            stop  = v.stop;
            sb.push_back(v);
            @(posedge clk);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            compare($sformatf("%s[%0d]", tag, i), {tone, busy, done, note_addr},
                    {e.tone, e.busy, e.done, e.addr});
        end
        vecs.delete();
    endtask

    task automatic add_all_eight();
        for (int i = 0; i < 8; i++) add_note(i % 3 + 1, 1, i);
        push(0, 0, 0, 0, 1, 7);
        push(0, 0, 0, 0, 0, 7);
        push(0, 0, 0, 0, 0, 7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        foreach (rom[i]) rom[i] = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare("reset", {tone, busy, done, note_addr}, 6'b0);
        rst = 1'b0;

        // Basic tune: tone, rest, end marker.
        rom[0] = mk(3, 2); rom[1] = mk(0, 1); rom[2] = mk(5, 0);
        add_note(3, 2, 0); add_note(0, 1, 1); add_end_marker(2);
        vecs[0].start = 1'b1;
        run("tune");

        // Same tune with start re-pulsed while busy: nothing may change.
        add_note(3, 2, 0); add_note(0, 1, 1); add_end_marker(2);
        vecs[0].start = 1'b1;
        vecs[1].start = 1'b1;
        vecs[5].start = 1'b1;
        vecs[12].start = 1'b1;
        run("start_busy");

        // Stop in the 6th PLAY clock of the second note, then start+stop together in IDLE.
        rom[0] = mk(1, 1); rom[1] = mk(3, 2);
        add_note(1, 1, 0);
        push(0, 0, 0, 1, 0, 1);
        push(0, 0, 0, 1, 0, 1);
        for (int k = 0; k < 6; k++) push(0, 0, 1'((k / 3) % 2), 1, 0, 1);
        push(0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0);
        push(1, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0);
        vecs[0].start = 1'b1;
        run("stop");

        // Eight notes, no end marker: done after address 7, no wrap.
        for (int i = 0; i < 8; i++) rom[i] = mk(i % 3 + 1, 1);
        add_all_eight();
        vecs[0].start = 1'b1;
        run("addr_end");

        // Reset while tone is high in note 2, then replay from address 0.
        add_note(1, 1, 0); add_note(2, 1, 1);
        push(0, 0, 0, 1, 0, 2);
        push(0, 0, 0, 1, 0, 2);
        for (int k = 0; k < 4; k++) push(0, 0, 1'((k / 3) % 2), 1, 0, 2);
        vecs[0].start = 1'b1;
        run("pre_rst");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compare("rst_mid", {tone, busy, done, note_addr}, 6'b0);
        rst = 1'b0;
        add_all_eight();
        vecs[0].start = 1'b1;
        run("replay");

        // Two identical notes; with the gap build they are separated by one silent tick.
        rom[0] = mk(2, 1); rom[1] = mk(2, 1); rom[2] = mk(7, 0);
        add_note(2, 1, 0); add_note(2, 1, 1); add_end_marker(2);
        vecs[0].start = 1'b1;
        run("gap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
